// File: rtl/mips_wdt_pkg.sv
// mips_wdt_pkg: shared watchdog state encodings and default parameter values
package mips_wdt_pkg;
    typedef enum logic [1:0] {
        WDT_IDLE  = 2'b00,
        WDT_COUNT = 2'b01,
        WDT_HOLD  = 2'b10
    } wdt_state_e;
    localparam int WDT_WIDTH          = 16;
    localparam int WDT_DEFAULT_PERIOD = 1000;
    localparam int WDT_HOLD_CYCLES    = 4;
    localparam int WDT_TCNT_WIDTH     = 8;
endpackage

// File: rtl/mips_wdt_ctrl_counter.sv
// wdt_load_down_counter: loadable down-counter with zero/one flags
//   clk_i, rst_ni : clock, async active-low reset (count clears to 0)
//   load_i        : load load_val_i (wins over dec_i)
//   dec_i         : decrement by one
//   cnt_o         : current count; zero_o / one_o flag cnt_o == 0 / 1
module wdt_load_down_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o,
    output logic         one_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load_i ? load_val_i : dec_i ? cnt_q - W'(1) : cnt_q;
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    assign cnt_o  = cnt_q;
    assign zero_o = cnt_q == '0;
    assign one_o  = cnt_q == W'(1);
endmodule

// File: rtl/mips_wdt_ctrl.sv
// mips_wdt_ctrl: watchdog that counts down a programmable period and pulses the CPU reset on expiry
//   i_clk, i_reset                      : clock, async active-low reset
//   i_enable                            : watchdog enable level
//   i_wait_period_w_en, i_wait_period   : period register write
//   i_kick                              : reload the running count
//   o_cpu_reset                         : HOLD_CYCLES-long reset pulse to the core
//   o_count, o_state, o_timeout_cnt     : down-counter, FSM state, saturating expiry count
module mips_wdt_ctrl
    import mips_wdt_pkg::*;
#(
    parameter int WIDTH          = WDT_WIDTH,
    parameter int DEFAULT_PERIOD = WDT_DEFAULT_PERIOD,
    parameter int HOLD_CYCLES    = WDT_HOLD_CYCLES,
    parameter int TCNT_WIDTH     = WDT_TCNT_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_wait_period_w_en,
    input  logic [WIDTH-1:0]      i_wait_period,
    input  logic                  i_kick,
    output logic                  o_cpu_reset,
    output logic [WIDTH-1:0]      o_count,
    output logic [1:0]            o_state,
    output logic [TCNT_WIDTH-1:0] o_timeout_cnt
);
    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    wdt_state_e            state_q;
    logic [WIDTH-1:0]      period_q;
    logic                  cpu_reset_q;
    logic [TCNT_WIDTH-1:0] tcnt_q;
    logic                  arm_ok, expire;
    logic                  cnt_load, cnt_dec, cnt_zero, cnt_one;
    logic                  hold_load, hold_dec, hold_zero, hold_one;
    logic [HW-1:0]         hold_cnt;
    logic                  unused_flags;
    assign arm_ok = i_enable && period_q != '0;
    // kick has priority over expiry, so expiry only fires on an unkicked count of 1
    assign expire = state_q == WDT_COUNT && arm_ok && !i_kick && cnt_one;
    always_comb begin
        cnt_load  = (state_q == WDT_IDLE && arm_ok) || (state_q == WDT_COUNT && arm_ok && i_kick) ||
                    (state_q == WDT_HOLD && hold_zero && arm_ok);
        cnt_dec   = state_q == WDT_COUNT && arm_ok && !i_kick && !cnt_one;
        hold_load = expire;
        hold_dec  = state_q == WDT_HOLD && !hold_zero;
    end
    wdt_load_down_counter #(.W(WIDTH)) u_main_cnt (
        .clk_i(i_clk), .rst_ni(i_reset), .load_i(cnt_load), .dec_i(cnt_dec),
        .load_val_i(period_q), .cnt_o(o_count), .zero_o(cnt_zero), .one_o(cnt_one)
    );
    wdt_load_down_counter #(.W(HW)) u_hold_cnt (
        .clk_i(i_clk), .rst_ni(i_reset), .load_i(hold_load), .dec_i(hold_dec),
        .load_val_i(HW'(HOLD_CYCLES - 1)), .cnt_o(hold_cnt), .zero_o(hold_zero), .one_o(hold_one)
    );
    assign unused_flags = cnt_zero ^ hold_one ^ ^hold_cnt;
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= WDT_IDLE;
            period_q    <= WIDTH'(DEFAULT_PERIOD);
            cpu_reset_q <= 1'b0;
            tcnt_q      <= '0;
        end else begin
            if (i_wait_period_w_en) period_q <= i_wait_period;
            case (state_q)
                WDT_IDLE:  if (arm_ok) state_q <= WDT_COUNT;
                WDT_COUNT: begin
                    if (!arm_ok) state_q <= WDT_IDLE;
                    else if (expire) begin
                        state_q     <= WDT_HOLD;
                        cpu_reset_q <= 1'b1;
                        tcnt_q      <= tcnt_q + TCNT_WIDTH'(tcnt_q != '1);
                    end
                end
                WDT_HOLD: begin
                    if (hold_zero) begin
                        cpu_reset_q <= 1'b0;
                        state_q     <= arm_ok ? WDT_COUNT : WDT_IDLE;
                    end
                end
                default: state_q <= WDT_IDLE;
            endcase
        end
    end
    assign o_cpu_reset   = cpu_reset_q;
    assign o_state       = state_q;
    assign o_timeout_cnt = tcnt_q;
endmodule

// File: tb/tb_mips_wdt_ctrl.sv
// tb_mips_wdt_ctrl: directed self-checking bench for mips_wdt_ctrl
module tb_mips_wdt_ctrl;
    import mips_wdt_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n, en, w_en, kick;
    logic [15:0] wp;
    logic        cpu_reset;
    logic [15:0] count;
    logic [1:0]  state;
    logic [1:0]  tcnt;
    int checks = 0;
    int failures = 0;
    int min_cnt;
    logic seen_rst;

    always #5 clk = ~clk;

    mips_wdt_ctrl #(
        .WIDTH(WDT_WIDTH), .DEFAULT_PERIOD(WDT_DEFAULT_PERIOD),
        .HOLD_CYCLES(WDT_HOLD_CYCLES), .TCNT_WIDTH(2)
    ) dut (
        .i_clk(clk), .i_reset(rst_n), .i_enable(en), .i_wait_period_w_en(w_en),
        .i_wait_period(wp), .i_kick(kick), .o_cpu_reset(cpu_reset), .o_count(count),
        .o_state(state), .o_timeout_cnt(tcnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic [15:0] c,
                           input logic r, input logic [1:0] t);
        chk({tag, "_state"}, 32'(state), 32'(st));
        chk({tag, "_count"}, 32'(count), 32'(c));
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(r));
        chk({tag, "_tcnt"}, 32'(tcnt), 32'(t));
    endtask

    task automatic write_period(input logic [15:0] v);
        w_en = 1'b1;
        wp   = v;
        step();
        w_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; w_en = 1'b0; kick = 1'b0; wp = '0;
        #12;
        chk_all("reset", 2'b00, 16'd0, 1'b0, 2'd0);
        rst_n = 1'b1;
        en    = 1'b1;
        // default period: arm, expire 1000 edges later, 4-cycle pulse, reload
        step();
        chk_all("arm_default", 2'b01, 16'd1000, 1'b0, 2'd0);
        seen_rst = 1'b0;
        for (int i = 0; i < 999; i++) begin
            step();
            seen_rst |= cpu_reset;
        end
        chk("t1_no_early_reset", 32'(seen_rst), 32'd0);
        chk_all("t1_before_expiry", 2'b01, 16'd1, 1'b0, 2'd0);
        step();
        chk_all("t1_expiry", 2'b10, 16'd1, 1'b1, 2'd1);
        steps(3);
        chk("t1_pulse_last", 32'(cpu_reset), 32'd1);
        step();
        chk_all("t1_reload", 2'b01, 16'd1000, 1'b0, 2'd1);
        // period 10 with a kick every 8 cycles never expires
        write_period(16'd10);
        chk("t2_write_no_effect", 32'(count), 32'd999);
        kick = 1'b1;
        step();
        kick = 1'b0;
        chk("t2_kick_load", 32'(count), 32'd10);
        min_cnt  = 10;
        seen_rst = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            kick = (i % 8 == 0);
            step();
            seen_rst |= cpu_reset;
            if (int'(count) < min_cnt) min_cnt = int'(count);
        end
        kick = 1'b0;
        chk("t2_no_reset", 32'(seen_rst), 32'd0);
        chk("t2_min_count", 32'(min_cnt), 32'd3);
        chk_all("t2_end", 2'b01, 16'd6, 1'b0, 2'd1);
        // period 5: kick at count==1 wins, then an unkicked run expires 5 edges after load
        write_period(16'd5);
        kick = 1'b1;
        step();
        kick = 1'b0;
        chk("t3_load5", 32'(count), 32'd5);
        steps(4);
        chk("t3_at_one", 32'(count), 32'd1);
        kick = 1'b1;
        step();
        kick = 1'b0;
        chk_all("t3_kick_wins", 2'b01, 16'd5, 1'b0, 2'd1);
        steps(4);
        chk_all("t3_pre_expiry", 2'b01, 16'd1, 1'b0, 2'd1);
        step();
        chk_all("t3_expiry", 2'b10, 16'd1, 1'b1, 2'd2);
        steps(4);
        chk_all("t3_reload", 2'b01, 16'd5, 1'b0, 2'd2);
        // period 20, rewrite to 7 mid-count: running count unaffected, reload uses 7
        write_period(16'd20);
        kick = 1'b1;
        step();
        kick = 1'b0;
        chk("t4_load20", 32'(count), 32'd20);
        steps(8);
        chk("t4_at12", 32'(count), 32'd12);
        write_period(16'd7);
        chk("t4_after_write", 32'(count), 32'd11);
        steps(10);
        chk_all("t4_pre_expiry", 2'b01, 16'd1, 1'b0, 2'd2);
        step();
        chk_all("t4_expiry", 2'b10, 16'd1, 1'b1, 2'd3);
        steps(4);
        chk_all("t4_reload7", 2'b01, 16'd7, 1'b0, 2'd3);
        // enable drop and kick during HOLD are ignored; counter saturates at 3
        steps(7);
        chk_all("t5_expiry_sat", 2'b10, 16'd1, 1'b1, 2'd3);
        en = 1'b0;
        step();
        chk("t5_hold_en_off", 32'(cpu_reset), 32'd1);
        kick = 1'b1;
        step();
        kick = 1'b0;
        chk_all("t5_hold_kick", 2'b10, 16'd1, 1'b1, 2'd3);
        step();
        chk("t5_hold_last", 32'(cpu_reset), 32'd1);
        step();
        chk_all("t5_to_idle", 2'b00, 16'd1, 1'b0, 2'd3);
        en = 1'b1;
        step();
        chk_all("t5_rearm", 2'b01, 16'd7, 1'b0, 2'd3);
        write_period(16'd0);
        chk("t5_write0_count", 32'(count), 32'd6);
        step();
        chk_all("t5_disabled", 2'b00, 16'd6, 1'b0, 2'd3);
        step();
        chk_all("t5_stay_idle", 2'b00, 16'd6, 1'b0, 2'd3);
        // period 2, async reset in the middle of HOLD
        write_period(16'd2);
        chk("t6_write_idle", 32'(state), 32'd0);
        step();
        chk_all("t6_arm2", 2'b01, 16'd2, 1'b0, 2'd3);
        steps(2);
        chk_all("t6_expiry", 2'b10, 16'd1, 1'b1, 2'd3);
        step();
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("t6_async_reset", 2'b00, 16'd0, 1'b0, 2'd0);
        rst_n = 1'b1;
        step();
        chk_all("t6_default_period", 2'b01, 16'd1000, 1'b0, 2'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
